// File: rtl/pipelined_channel_min_window_if.sv
// pipelined_channel_min_window_if: pixel stream in, per-pixel and windowed minimum out.
interface pipelined_channel_min_window_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3,
    parameter int SEL_W  = 2
);
    logic                     in_valid;
    logic                     in_sol;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_min;
    logic [SEL_W-1:0]         out_sel;
    logic [DATA_W-1:0]        out_win_min;

    modport master (
        output in_valid, in_sol, in_data,
        input  out_valid, out_min, out_sel, out_win_min
    );

    modport slave (
        input  in_valid, in_sol, in_data,
        output out_valid, out_min, out_sel, out_win_min
    );
endinterface

// File: rtl/pipelined_channel_min_window.sv
// pipelined_channel_min_window: 2-stage per-pixel channel minimum plus trailing
// line-local window minimum over the last WIN valid pixels.
module pipelined_channel_min_window #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3,
    parameter int WIN    = 3,
    parameter int SEL_W  = 2
) (
    input logic                           clk,
    input logic                           rst_n,
    pipelined_channel_min_window_if.slave bus
);
    localparam logic [DATA_W-1:0] ONES = '1;

    logic [DATA_W-1:0] ch_min, win_min;
    logic [SEL_W-1:0]  ch_sel;
    logic              s1_valid_q, s1_valid_d, s1_sol_q, s1_sol_d;
    logic [DATA_W-1:0] s1_min_q, s1_min_d;
    logic [SEL_W-1:0]  s1_sel_q, s1_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_min_q, out_min_d, out_win_q, out_win_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;

    // Strict less-than keeps the lowest channel index on ties
    always_comb begin
        ch_min = bus.in_data[DATA_W-1:0];
        ch_sel = '0;
        for (int i = 1; i < NUM_CH; i++) begin
            if (bus.in_data[i*DATA_W +: DATA_W] < ch_min) begin
                ch_min = bus.in_data[i*DATA_W +: DATA_W];
                ch_sel = SEL_W'(i);
            end
        end
        s1_valid_d  = bus.in_valid;
        s1_sol_d    = bus.in_valid & bus.in_sol;
        s1_min_d    = bus.in_valid ? ch_min : s1_min_q;
        s1_sel_d    = bus.in_valid ? ch_sel : s1_sel_q;
        out_valid_d = s1_valid_q;
        out_min_d   = s1_valid_q ? s1_min_q : out_min_q;
        out_sel_d   = s1_valid_q ? s1_sel_q : out_sel_q;
        out_win_d   = s1_valid_q ? win_min : out_win_q;
    end

    generate
        if (WIN > 1) begin : g_hist
            logic [DATA_W-1:0] hist_q [WIN-1];
            logic [DATA_W-1:0] hist_d [WIN-1];
            logic [DATA_W-1:0] eff    [WIN-1];
            // All-ones padding on sol keeps the window from spanning lines
            always_comb begin
                win_min = s1_min_q;
                for (int k = 0; k < WIN-1; k++) begin
                    eff[k] = s1_sol_q ? ONES : hist_q[k];
                    if (eff[k] < win_min) win_min = eff[k];
                end
                hist_d = hist_q;
                if (s1_valid_q) begin
                    hist_d[0] = s1_min_q;
                    for (int k = 1; k < WIN-1; k++) hist_d[k] = eff[k-1];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < WIN-1; k++) hist_q[k] <= ONES;
                end else begin
                    hist_q <= hist_d;
                end
            end
        end else begin : g_nohist
            assign win_min = s1_min_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sol_q    <= 1'b0;
            s1_min_q    <= '0;
            s1_sel_q    <= '0;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_sel_q   <= '0;
            out_win_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sol_q    <= s1_sol_d;
            s1_min_q    <= s1_min_d;
            s1_sel_q    <= s1_sel_d;
            out_valid_q <= out_valid_d;
            out_min_q   <= out_min_d;
            out_sel_q   <= out_sel_d;
            out_win_q   <= out_win_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_min     = out_min_q;
    assign bus.out_sel     = out_sel_q;
    assign bus.out_win_min = out_win_q;
endmodule

// File: tb/tb_pipelined_channel_min_window.sv
// tb_pipelined_channel_min_window: table-driven vectors checked through a
// latency-tagged scoreboard, plus reset sequences.
module tb_pipelined_channel_min_window;
    typedef struct {
        bit         v;
        bit         sol;
        logic [7:0] r, g, b;
        logic [7:0] m;
        logic [1:0] s;
        logic [7:0] w;
    } vec_t;

    typedef struct {
        logic [7:0] m;
        logic [1:0] s;
        logic [7:0] w;
        int         due;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    int   cyc = 0;
    int   chk = 0;
    int   errs = 0;
    exp_t q[$];
    exp_t last;
    bit   have_last = 0;
    vec_t tv[22];

    pipelined_channel_min_window_if #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) bus ();

    pipelined_channel_min_window #(.DATA_W(8), .NUM_CH(3), .WIN(3), .SEL_W(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        chk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int v, input int sol, input int r, input int g,
                                input int b, input int m, input int s, input int w);
        vec_t t;
        t.v = v[0]; t.sol = sol[0];
        t.r = 8'(r); t.g = 8'(g); t.b = 8'(b);
        t.m = 8'(m); t.s = 2'(s); t.w = 8'(w);
        return t;
    endfunction

    task automatic drive(input vec_t t);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid = t.v;
        bus.in_sol   = t.sol;
        bus.in_data  = {t.b, t.g, t.r};
        if (t.v) begin
            e.m = t.m; e.s = t.s; e.w = t.w; e.due = cyc + 2;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            have_last = 0;
        end else if (bus.out_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                last = q.pop_front();
                check("latency", cyc, last.due);
                check("out_min", int'(bus.out_min), int'(last.m));
                check("out_sel", int'(bus.out_sel), int'(last.s));
                check("out_win_min", int'(bus.out_win_min), int'(last.w));
                have_last = 1;
            end
        end else begin
            if (q.size() != 0 && q[0].due <= cyc) begin
                check("missing_valid", 0, 1);
                void'(q.pop_front());
            end
            if (have_last) begin
                check("hold_min", int'(bus.out_min), int'(last.m));
                check("hold_win", int'(bus.out_win_min), int'(last.w));
            end
        end
    end

    initial begin
        tv[0]  = mk(1, 0, 30, 20, 40, 20, 1, 20);
        tv[1]  = mk(1, 0, 7, 7, 7, 7, 0, 7);
        tv[2]  = mk(1, 0, 9, 5, 5, 5, 1, 5);
        tv[3]  = mk(1, 0, 9, 6, 5, 5, 2, 5);
        tv[4]  = mk(1, 1, 50, 60, 70, 50, 0, 50);
        tv[5]  = mk(1, 0, 20, 10, 30, 10, 1, 10);
        tv[6]  = mk(1, 0, 90, 80, 60, 60, 2, 10);
        tv[7]  = mk(1, 0, 70, 70, 71, 70, 0, 10);
        tv[8]  = mk(1, 0, 80, 81, 82, 80, 0, 60);
        tv[9]  = mk(1, 0, 5, 200, 9, 5, 0, 5);
        tv[10] = mk(1, 0, 3, 4, 5, 3, 0, 3);
        tv[11] = mk(1, 1, 90, 91, 92, 90, 0, 90);
        tv[12] = mk(1, 0, 95, 96, 97, 95, 0, 90);
        tv[13] = mk(1, 1, 8, 8, 9, 8, 0, 8);
        tv[14] = mk(0, 1, 1, 1, 1, 0, 0, 0);
        tv[15] = mk(0, 0, 2, 2, 2, 0, 0, 0);
        tv[16] = mk(1, 0, 4, 40, 40, 4, 0, 4);
        tv[17] = mk(1, 0, 60, 6, 60, 6, 1, 4);
        tv[18] = mk(0, 1, 0, 0, 0, 0, 0, 0);
        tv[19] = mk(1, 0, 9, 9, 9, 9, 0, 4);
        tv[20] = mk(1, 1, 255, 255, 255, 255, 0, 255);
        tv[21] = mk(1, 0, 255, 255, 255, 255, 0, 255);

        bus.in_valid = 1;
        bus.in_sol   = 1;
        bus.in_data  = {8'd40, 8'd20, 8'd30};
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_min", int'(bus.out_min), 0);
        check("rst_sel", int'(bus.out_sel), 0);
        check("rst_win", int'(bus.out_win_min), 0);
        bus.in_valid = 0;
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 22; i++) drive(tv[i]);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (4) @(posedge clk);

        drive(mk(1, 0, 100, 150, 120, 100, 0, 100));
        drive(mk(1, 0, 50, 60, 70, 50, 0, 50));
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        check("pre_rst_valid", int'(bus.out_valid), 1);
        check("pre_rst_min", int'(bus.out_min), 100);
        #2;
        rst_n = 0;
        #1;
        check("async_valid", int'(bus.out_valid), 0);
        check("async_min", int'(bus.out_min), 0);
        check("async_sel", int'(bus.out_sel), 0);
        check("async_win", int'(bus.out_win_min), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        drive(mk(1, 0, 77, 70, 200, 70, 1, 70));
        drive(mk(1, 0, 80, 90, 85, 80, 0, 70));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end
endmodule
